// File: rtl/pdp_pkg.sv
// Shared types for the PDP memory arbiter.
//   arb_state_e : arbiter FSM states
//   req_id_e    : which requester owns the current memory access
//   mem_req_s   : one captured request {is_wr, addr, data}
package pdp_pkg;

  localparam int PDP_AW = 12;
  localparam int PDP_DW = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IFU  = 1'b0,
    REQ_EXEC = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              is_wr;
    logic [PDP_AW-1:0] addr;
    logic [PDP_DW-1:0] data;
  } mem_req_s;

endpackage

// File: rtl/pdp_req_slot.sv
// One-deep request holding register.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : request pulse; captured when the slot is empty or being freed
//   load_req     : request contents sampled with load
//   clear        : frees the slot (service complete)
//   busy         : slot occupied
//   req          : held request
//   overflow     : pulse, a load arrived while the slot was occupied and not freeing
module pdp_req_slot
  import pdp_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  mem_req_s load_req,
  input  logic     clear,
  output logic     busy,
  output mem_req_s req,
  output logic     overflow
);

  logic accept;

  // A clear in the same cycle as a load lets the slot be refilled with no gap.
  assign accept   = load && (!busy || clear);
  assign overflow = load && busy && !clear;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      req  <= '0;
    end else if (accept) begin
      busy <= 1'b1;
      req  <= load_req;
    end else if (clear) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Arbiter sharing the single-port PDP memory between instruction fetch and
// the execution unit. Exec has priority; a starvation counter forces fetch to
// win after STARVE_LIMIT consecutive lost arbitrations.
//   clk, reset_n                 : clock, synchronous active-low reset
//   ifu_rd_req/addr              : fetch read request
//   ifu_rd_data/valid, ifu_busy  : fetch read return, slot occupied
//   exec_rd_req/addr             : exec read request
//   exec_wr_req/addr/data        : exec write request
//   exec_rd_data/valid           : exec read return
//   exec_wr_done, exec_busy      : write committed pulse, slot occupied
//   mem_rd_req/wr_req/addr/wr_data, mem_rd_data : memory port
//   err_overflow                 : sticky, a request was dropped
//
// state | meaning
// IDLE  | choose a winner among pending slots, load the memory strobes
// ISSUE | strobe on the memory port; writes complete here
// DATA  | read data returned to the winner, its slot freed
module pdp_mem_arbiter
  import pdp_pkg::*;
#(
  parameter int ADDR_WIDTH   = PDP_AW,
  parameter int DATA_WIDTH   = PDP_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  output logic                  ifu_busy,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  output logic                  exec_wr_done,
  output logic                  exec_busy,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  err_overflow
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  req_id_e    win_q, win_d;
  logic       cur_is_wr_q, is_wr_d;
  logic [SW-1:0] starve_q, starve_d;

  logic mem_rd_req_d, mem_wr_req_d, wr_done_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_d;
  logic [DATA_WIDTH-1:0] ifu_rd_data_q, exec_rd_data_q;

  mem_req_s ifu_ld, exec_ld, ifu_q, exec_q, pick;
  logic     ifu_clr, exec_clr, ifu_ovf, exec_ovf, exec_load, exec_both;

  // Simultaneous exec read and write: the read is kept, the write is lost.
  assign exec_both = exec_rd_req && exec_wr_req;
  assign exec_load = exec_rd_req || exec_wr_req;

  always_comb begin
    ifu_ld       = '0;
    ifu_ld.addr  = ifu_rd_addr;
    exec_ld      = '0;
    if (exec_rd_req) begin
      exec_ld.addr  = exec_rd_addr;
    end else begin
      exec_ld.is_wr = 1'b1;
      exec_ld.addr  = exec_wr_addr;
      exec_ld.data  = exec_wr_data;
    end
  end

  pdp_req_slot u_ifu_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ifu_rd_req),
    .load_req (ifu_ld),
    .clear    (ifu_clr),
    .busy     (ifu_busy),
    .req      (ifu_q),
    .overflow (ifu_ovf)
  );

  pdp_req_slot u_exec_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (exec_load),
    .load_req (exec_ld),
    .clear    (exec_clr),
    .busy     (exec_busy),
    .req      (exec_q),
    .overflow (exec_ovf)
  );

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    is_wr_d       = cur_is_wr_q;
    starve_d      = starve_q;
    mem_rd_req_d  = 1'b0;
    mem_wr_req_d  = 1'b0;
    wr_done_d     = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wr_data_d = mem_wr_data;
    ifu_clr       = 1'b0;
    exec_clr      = 1'b0;
    pick          = exec_q;
    unique case (state_q)
      IDLE: begin
        if (ifu_busy || exec_busy) begin
          if (ifu_busy && (!exec_busy || starve_q == LIMIT)) begin
            win_d    = REQ_IFU;
            pick     = ifu_q;
            starve_d = '0;
          end else begin
            win_d = REQ_EXEC;
            pick  = exec_q;
            if (ifu_busy && starve_q != LIMIT) starve_d = starve_q + SW'(1);
          end
          // Strobes are registered so they appear exactly in ISSUE.
          is_wr_d      = pick.is_wr;
          mem_addr_d   = pick.addr;
          mem_rd_req_d = !pick.is_wr;
          mem_wr_req_d = pick.is_wr;
          wr_done_d    = pick.is_wr;
          if (pick.is_wr) mem_wr_data_d = pick.data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_is_wr_q) begin
          exec_clr = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (win_q == REQ_IFU) ifu_clr = 1'b1;
        else                  exec_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      win_q          <= REQ_IFU;
      cur_is_wr_q    <= 1'b0;
      starve_q       <= '0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;
      mem_addr       <= '0;
      mem_wr_data    <= '0;
      exec_wr_done   <= 1'b0;
      ifu_rd_data_q  <= '0;
      exec_rd_data_q <= '0;
      err_overflow   <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cur_is_wr_q  <= is_wr_d;
      starve_q     <= starve_d;
      mem_rd_req   <= mem_rd_req_d;
      mem_wr_req   <= mem_wr_req_d;
      mem_addr     <= mem_addr_d;
      mem_wr_data  <= mem_wr_data_d;
      exec_wr_done <= wr_done_d;
      if (ifu_rd_valid)  ifu_rd_data_q  <= mem_rd_data;
      if (exec_rd_valid) exec_rd_data_q <= mem_rd_data;
      if (ifu_ovf || exec_ovf || exec_both) err_overflow <= 1'b1;
    end
  end

  // Read data is passed straight through in DATA; valid is masked by reset so
  // a reset landing on the DATA cycle abandons the read without a pulse.
  assign ifu_rd_valid  = reset_n && (state_q == DATA) && (win_q == REQ_IFU);
  assign exec_rd_valid = reset_n && (state_q == DATA) && (win_q == REQ_EXEC);
  assign ifu_rd_data   = ifu_rd_valid  ? mem_rd_data : ifu_rd_data_q;
  assign exec_rd_data  = exec_rd_valid ? mem_rd_data : exec_rd_data_q;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
module tb_pdp_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ifu_rd_req = 1'b0;
  logic [11:0] ifu_rd_addr = '0;
  logic [11:0] ifu_rd_data;
  logic        ifu_rd_valid, ifu_busy;
  logic        exec_rd_req = 1'b0;
  logic [11:0] exec_rd_addr = '0;
  logic        exec_wr_req = 1'b0;
  logic [11:0] exec_wr_addr = '0;
  logic [11:0] exec_wr_data = '0;
  logic [11:0] exec_rd_data;
  logic        exec_rd_valid, exec_wr_done, exec_busy;
  logic        mem_rd_req, mem_wr_req;
  logic [11:0] mem_addr, mem_wr_data;
  logic [11:0] mem_rd_data = '0;
  logic        err_overflow;

  pdp_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .ifu_rd_valid(ifu_rd_valid), .ifu_busy(ifu_busy),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_rd_data(exec_rd_data), .exec_rd_valid(exec_rd_valid),
    .exec_wr_done(exec_wr_done), .exec_busy(exec_busy),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory attached to the DUT port, and the model's own copy of memory.
  logic [11:0] tb_mem [0:4095];
  logic [11:0] m_mem  [0:4095];
  always @(posedge clk) begin
    if (mem_rd_req) mem_rd_data <= tb_mem[mem_addr];
    if (mem_wr_req) tb_mem[mem_addr] <= mem_wr_data;
  end

  int nchk = 0;
  int nerr = 0;

  function automatic void chk1(input string nm, input logic a, input logic e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, a, e);
    end
  endfunction

  function automatic void chk12(input string nm, input logic [11:0] a, input logic [11:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%o want=%o", nm, cyc, a, e);
    end
  endfunction

  // Transaction-level model: pending requests, one access in flight that
  // started arbitration at m_t0, strobe at m_t0+1, read data at m_t0+2.
  logic        m_ifu_pend, m_ex_pend, m_ex_wr, m_act, m_who_ex, m_wr, m_err;
  logic [11:0] m_ifu_addr, m_ex_addr, m_ex_data, m_addr, m_data;
  logic [11:0] m_ifu_last, m_ex_last;
  int          m_t0, m_starve;
  logic        e_rd, e_wr, e_dat, e_ifu_v, e_ex_v;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk1("rst_ifu_valid", ifu_rd_valid, 1'b0);
      chk1("rst_exec_valid", exec_rd_valid, 1'b0);
      m_ifu_pend = 0; m_ex_pend = 0; m_act = 0; m_starve = 0; m_err = 0;
      m_ifu_last = '0; m_ex_last = '0;
    end else begin
      if (!m_act && (m_ifu_pend || m_ex_pend)) begin
        m_act = 1; m_t0 = cyc;
        if (m_ifu_pend && (!m_ex_pend || m_starve == LIM)) begin
          m_who_ex = 0; m_wr = 0; m_addr = m_ifu_addr; m_starve = 0;
        end else begin
          m_who_ex = 1; m_wr = m_ex_wr; m_addr = m_ex_addr; m_data = m_ex_data;
          if (m_ifu_pend && m_starve < LIM) m_starve++;
        end
      end
      e_rd    = m_act && !m_wr && (cyc == m_t0 + 1);
      e_wr    = m_act &&  m_wr && (cyc == m_t0 + 1);
      e_dat   = m_act && !m_wr && (cyc == m_t0 + 2);
      e_ifu_v = e_dat && !m_who_ex;
      e_ex_v  = e_dat &&  m_who_ex;
      if (e_ifu_v) m_ifu_last = m_mem[m_addr];
      if (e_ex_v)  m_ex_last  = m_mem[m_addr];

      chk1("m_ifu_busy", ifu_busy, m_ifu_pend);
      chk1("m_exec_busy", exec_busy, m_ex_pend);
      chk1("m_mem_rd_req", mem_rd_req, e_rd);
      chk1("m_mem_wr_req", mem_wr_req, e_wr);
      if (e_rd || e_wr) chk12("m_mem_addr", mem_addr, m_addr);
      if (e_wr) chk12("m_mem_wr_data", mem_wr_data, m_data);
      chk1("m_exec_wr_done", exec_wr_done, e_wr);
      chk1("m_ifu_rd_valid", ifu_rd_valid, e_ifu_v);
      chk1("m_exec_rd_valid", exec_rd_valid, e_ex_v);
      chk12("m_ifu_rd_data", ifu_rd_data, m_ifu_last);
      chk12("m_exec_rd_data", exec_rd_data, m_ex_last);
      chk1("m_err_overflow", err_overflow, m_err);

      if (e_wr) begin m_mem[m_addr] = m_data; m_ex_pend = 0; m_act = 0; end
      if (e_dat) begin
        if (m_who_ex) m_ex_pend = 0; else m_ifu_pend = 0;
        m_act = 0;
      end

      if (ifu_rd_req) begin
        if (m_ifu_pend) m_err = 1;
        else begin m_ifu_pend = 1; m_ifu_addr = ifu_rd_addr; end
      end
      if (exec_rd_req && exec_wr_req) m_err = 1;
      if (exec_rd_req || exec_wr_req) begin
        if (m_ex_pend) m_err = 1;
        else begin
          m_ex_pend = 1;
          m_ex_wr   = !exec_rd_req;
          m_ex_addr = exec_rd_req ? exec_rd_addr : exec_wr_addr;
          m_ex_data = exec_wr_data;
        end
      end
    end
  end

  task automatic goto(input int c);
    int g = 0;
    while (cyc < c && g < 1000) begin @(posedge clk); #1; g++; end
  endtask

  task automatic wait_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int t, t2;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i] = 12'(i) ^ 12'o5252;
      m_mem[i]  = 12'(i) ^ 12'o5252;
    end
    tb_mem[12'o200] = 12'o7200; m_mem[12'o200] = 12'o7200;
    tb_mem[12'o100] = 12'o1111; m_mem[12'o100] = 12'o1111;
    tb_mem[12'o050] = 12'o2222; m_mem[12'o050] = 12'o2222;
    tb_mem[12'o300] = 12'o4321; m_mem[12'o300] = 12'o4321;

    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    wait_neg(cyc);
    chk1("reset_ifu_busy", ifu_busy, 1'b0);
    chk1("reset_exec_busy", exec_busy, 1'b0);
    chk1("reset_mem_rd_req", mem_rd_req, 1'b0);
    chk1("reset_err", err_overflow, 1'b0);
    chk12("reset_ifu_data", ifu_rd_data, 12'o0);

    // Lone fetch
    t = cyc + 1; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o200; step(); ifu_rd_req = 0;
    wait_neg(t + 1); chk1("fetch_busy_c1", ifu_busy, 1'b1);
    wait_neg(t + 2); chk1("fetch_rdreq_c2", mem_rd_req, 1'b1);
    chk12("fetch_addr_c2", mem_addr, 12'o200);
    wait_neg(t + 3); chk1("fetch_valid_c3", ifu_rd_valid, 1'b1);
    chk12("fetch_data_c3", ifu_rd_data, 12'o7200);
    chk1("fetch_busy_c3", ifu_busy, 1'b1);
    wait_neg(t + 4); chk1("fetch_busy_c4", ifu_busy, 1'b0);
    chk12("fetch_data_hold", ifu_rd_data, 12'o7200);

    // Collision: exec first, fetch second
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o100; exec_rd_req = 1; exec_rd_addr = 12'o050;
    step(); ifu_rd_req = 0; exec_rd_req = 0;
    wait_neg(t + 3); chk1("coll_exec_valid", exec_rd_valid, 1'b1);
    chk12("coll_exec_data", exec_rd_data, 12'o2222);
    chk1("coll_ifu_not_yet", ifu_rd_valid, 1'b0);
    wait_neg(t + 6); chk1("coll_ifu_valid", ifu_rd_valid, 1'b1);
    chk12("coll_ifu_data", ifu_rd_data, 12'o1111);

    // Exec write, then read back
    t = cyc + 2; goto(t);
    exec_wr_req = 1; exec_wr_addr = 12'o020; exec_wr_data = 12'o1234;
    step(); exec_wr_req = 0;
    wait_neg(t + 2); chk1("wr_strobe", mem_wr_req, 1'b1);
    chk1("wr_no_rd", mem_rd_req, 1'b0);
    chk12("wr_addr", mem_addr, 12'o020);
    chk12("wr_data", mem_wr_data, 12'o1234);
    chk1("wr_done", exec_wr_done, 1'b1);
    t2 = cyc + 2; goto(t2);
    exec_rd_req = 1; exec_rd_addr = 12'o020; step(); exec_rd_req = 0;
    wait_neg(t2 + 3); chk1("wr_rb_valid", exec_rd_valid, 1'b1);
    chk12("wr_rb_data", exec_rd_data, 12'o1234);

    // Starvation: exec refired on each of its data cycles
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o300; exec_rd_req = 1; exec_rd_addr = 12'o301;
    step(); ifu_rd_req = 0; exec_rd_req = 0;
    for (int k = 1; k <= 4; k++) begin
      goto(t + 3 * k);
      chk1("starve_exec_valid", exec_rd_valid, 1'b1);
      exec_rd_req = 1; exec_rd_addr = 12'o301 + 12'(k);
      step(); exec_rd_req = 0;
    end
    wait_neg(t + 15); chk1("starve_ifu_granted", ifu_rd_valid, 1'b1);
    chk12("starve_ifu_data", ifu_rd_data, 12'o4321);
    wait_neg(t + 18); chk1("starve_exec5_valid", exec_rd_valid, 1'b1);
    // Counter back at 0: a fresh collision goes to exec first
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o100; exec_rd_req = 1; exec_rd_addr = 12'o050;
    step(); ifu_rd_req = 0; exec_rd_req = 0;
    wait_neg(t + 3); chk1("starve_clr_exec_first", exec_rd_valid, 1'b1);
    wait_neg(t + 6); chk1("starve_clr_ifu_second", ifu_rd_valid, 1'b1);

    // Overflow: second fetch while busy
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o100; step();
    ifu_rd_addr = 12'o200; step(); ifu_rd_req = 0;
    wait_neg(t + 2); chk1("ovf_err_set", err_overflow, 1'b1);
    wait_neg(t + 3); chk12("ovf_kept_data", ifu_rd_data, 12'o1111);
    wait_neg(t + 6); chk1("ovf_dropped_no_valid", ifu_rd_valid, 1'b0);

    // Exec read+write same cycle
    goto(cyc + 1); reset_n = 0; step(); reset_n = 1;
    wait_neg(cyc); chk1("rst2_err_clr", err_overflow, 1'b0);
    t = cyc + 2; goto(t);
    exec_rd_req = 1; exec_rd_addr = 12'o050;
    exec_wr_req = 1; exec_wr_addr = 12'o060; exec_wr_data = 12'o7777;
    step(); exec_rd_req = 0; exec_wr_req = 0;
    wait_neg(t + 1); chk1("rw_err", err_overflow, 1'b1);
    wait_neg(t + 2); chk1("rw_is_read", mem_rd_req, 1'b1);
    chk1("rw_no_write", mem_wr_req, 1'b0);
    wait_neg(t + 3); chk12("rw_read_data", exec_rd_data, 12'o2222);
    wait_neg(t + 4); chk1("rw_write_gone", exec_busy, 1'b0);

    // Reset during the data cycle of a read
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o200; step(); ifu_rd_req = 0;
    goto(t + 3); reset_n = 0;
    wait_neg(t + 3); chk1("rstmid_no_valid", ifu_rd_valid, 1'b0);
    step(); reset_n = 1;
    wait_neg(t + 4);
    chk1("rstmid_busy0", ifu_busy, 1'b0);
    chk1("rstmid_valid0", ifu_rd_valid, 1'b0);
    chk12("rstmid_data0", ifu_rd_data, 12'o0);
    chk1("rstmid_rdreq0", mem_rd_req, 1'b0);
    t = cyc + 2; goto(t);
    ifu_rd_req = 1; ifu_rd_addr = 12'o100; step(); ifu_rd_req = 0;
    wait_neg(t + 3); chk1("rstmid_fresh_valid", ifu_rd_valid, 1'b1);
    chk12("rstmid_fresh_data", ifu_rd_data, 12'o1111);

    goto(cyc + 5);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
